cpuc_mem_arbiter: RTL and testbench



---
 rtl/cpuc_package.sv | 20 ++
 rtl/cpuc_arb_wait_cnt.sv | 44 ++++
 rtl/cpuc_mem_arbiter.sv | 81 ++++++++
 tb/tb_cpuc_mem_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpuc_package.sv
// Shared CPUC widths and the request/arbitration types used by the data RAM arbiter.
package cpuc_package;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 16;
  localparam int MEM_SIZE   = 256;

  typedef struct packed {
    logic                  valid;
    logic                  wren;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } t_mem_req;

  typedef enum logic {
    ARB_NORMAL,
    ARB_BOOST
  } t_arb_mode;

endpackage

// File: rtl/cpuc_arb_wait_cnt.sv
// Counts consecutive blocked loader cycles and raises BOOST one cycle after the count saturates.
module cpuc_arb_wait_cnt
  import cpuc_package::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      ldr_valid,
  input  logic      ldr_grant,
  output t_arb_mode mode
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_next;
  t_arb_mode         mode_next;
  logic              blocked;

  always_comb begin
    blocked       = ldr_valid && !ldr_grant;
    wait_cnt_next = '0;
    mode_next     = ARB_NORMAL;
    if (blocked) begin
      wait_cnt_next = (wait_cnt == WAIT_MAX) ? WAIT_MAX : wait_cnt + WAIT_W'(1);
      // A loader grant in BOOST clears blocked, so mode falls back to NORMAL next cycle.
      if (wait_cnt == WAIT_MAX) mode_next = ARB_BOOST;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      mode     <= ARB_NORMAL;
    end else begin
      wait_cnt <= wait_cnt_next;
      mode     <= mode_next;
    end
  end

endmodule

// File: rtl/cpuc_mem_arbiter.sv
// Arbitrates the single-port CPUC data RAM between the core and the loader/debug port.
module cpuc_mem_arbiter
  import cpuc_package::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_valid,
  output logic                  core_ready,
  input  logic                  core_wren,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_rsp_valid,
  output logic [DATA_WIDTH-1:0] core_rsp_data,
  input  logic                  ldr_valid,
  output logic                  ldr_ready,
  input  logic                  ldr_wren,
  input  logic [ADDR_WIDTH-1:0] ldr_addr,
  input  logic [DATA_WIDTH-1:0] ldr_wdata,
  output logic                  ldr_rsp_valid,
  output logic [DATA_WIDTH-1:0] ldr_rsp_data,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_wren,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  t_arb_mode mode;
  t_mem_req  core_req;
  t_mem_req  ldr_req;
  t_mem_req  sel_req;
  logic      core_grant;
  logic      ldr_grant;

  assign core_req = '{valid: core_valid, wren: core_wren, addr: core_addr, wdata: core_wdata};
  assign ldr_req  = '{valid: ldr_valid,  wren: ldr_wren,  addr: ldr_addr,  wdata: ldr_wdata};

  cpuc_arb_wait_cnt #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_wait_cnt (
    .clk       (clk),
    .rst       (rst),
    .ldr_valid (ldr_valid),
    .ldr_grant (ldr_grant),
    .mode      (mode)
  );

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    ldr_grant  = ldr_req.valid && (mode == ARB_BOOST || !core_req.valid);
    core_grant = core_req.valid && !ldr_grant;
    sel_req    = '0;
    if (core_grant)     sel_req = core_req;
    else if (ldr_grant) sel_req = ldr_req;
  end

  assign core_ready  = core_grant;
  assign ldr_ready   = ldr_grant;
  assign ram_address = sel_req.addr;
  assign ram_data    = sel_req.wdata;
  assign ram_wren    = sel_req.valid && sel_req.wren;

  // ram_q is a combinational read of the granted address, captured at the end of the grant cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_rsp_valid <= 1'b0;
      ldr_rsp_valid  <= 1'b0;
      core_rsp_data  <= '0;
      ldr_rsp_data   <= '0;
    end else begin
      core_rsp_valid <= core_grant && !core_req.wren;
      ldr_rsp_valid  <= ldr_grant && !ldr_req.wren;
      if (core_grant && !core_req.wren) core_rsp_data <= ram_q;
      if (ldr_grant && !ldr_req.wren)   ldr_rsp_data  <= ram_q;
    end
  end

endmodule

// File: tb/tb_cpuc_mem_arbiter.sv
// Scoreboarded bench for cpuc_mem_arbiter with a behavioural RAM and a reference arbitration model.
module tb_cpuc_mem_arbiter;
  import cpuc_package::*;

  localparam int MAXW = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  core_valid = 1'b0, core_wren = 1'b0;
  logic [ADDR_WIDTH-1:0] core_addr = '0;
  logic [DATA_WIDTH-1:0] core_wdata = '0;
  logic                  ldr_valid = 1'b0, ldr_wren = 1'b0;
  logic [ADDR_WIDTH-1:0] ldr_addr = '0;
  logic [DATA_WIDTH-1:0] ldr_wdata = '0;
  logic                  core_ready, ldr_ready, core_rsp_valid, ldr_rsp_valid, ram_wren;
  logic [DATA_WIDTH-1:0] core_rsp_data, ldr_rsp_data, ram_data, ram_q;
  logic [ADDR_WIDTH-1:0] ram_address;

  cpuc_mem_arbiter #(.MAX_WAIT(MAXW), .WAIT_W(4)) dut (
    .clk(clk), .rst(rst),
    .core_valid(core_valid), .core_ready(core_ready), .core_wren(core_wren),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data),
    .ldr_valid(ldr_valid), .ldr_ready(ldr_ready), .ldr_wren(ldr_wren),
    .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rsp_valid(ldr_rsp_valid), .ldr_rsp_data(ldr_rsp_data),
    .ram_address(ram_address), .ram_wren(ram_wren), .ram_data(ram_data), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM standing in for cpuc_single_ram.
  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
  assign ram_q = mem[ram_address];
  always @(posedge clk) if (ram_wren) mem[ram_address] <= ram_data;

  // Reference model state: expected memory contents and loader starvation streak.
  logic [DATA_WIDTH-1:0] ref_mem [MEM_SIZE];
  int streak = 0;
  int cyc = 0;
  bit core_acc = 0, ldr_acc = 0;

  typedef struct { int cyc; logic [DATA_WIDTH-1:0] data; } exp_t;
  exp_t core_q[$];
  exp_t ldr_q[$];
  logic [DATA_WIDTH-1:0] last_core = '0, last_ldr = '0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Checker: arbitration and RAM drive against the model; pushes expected read responses.
  always @(negedge clk) begin
    bit el, ec, ew;
    logic [ADDR_WIDTH-1:0] ea;
    logic [DATA_WIDTH-1:0] ed;
    if (rst) begin
      streak   = 0;
      core_acc = 0;
      ldr_acc  = 0;
    end else begin
      // Loader wins if it has been blocked for more than MAXW straight cycles, or the core is idle.
      el = ldr_valid && (streak > MAXW || !core_valid);
      ec = core_valid && !el;
      ew = 0; ea = '0; ed = '0;
      if (ec)      begin ew = core_wren; ea = core_addr; ed = core_wdata; end
      else if (el) begin ew = ldr_wren;  ea = ldr_addr;  ed = ldr_wdata;  end
      check("core_ready", core_ready, ec);
      check("ldr_ready", ldr_ready, el);
      check("ram_wren", ram_wren, ew);
      check("ram_address", ram_address, ea);
      check("ram_data", ram_data, ed);
      if (ec) begin
        if (core_wren) ref_mem[core_addr] = core_wdata;
        else core_q.push_back('{cyc, ref_mem[core_addr]});
      end
      if (el) begin
        if (ldr_wren) ref_mem[ldr_addr] = ldr_wdata;
        else ldr_q.push_back('{cyc, ref_mem[ldr_addr]});
      end
      streak   = (ldr_valid && !el) ? streak + 1 : 0;
      core_acc = ec;
      ldr_acc  = el;
    end
  end

  // Monitor: each response port must pulse exactly one cycle after its read was granted.
  always @(negedge clk) begin
    bit   ev;
    exp_t e;
    if (rst) begin
      core_q.delete();
      ldr_q.delete();
      last_core = '0;
      last_ldr  = '0;
    end else begin
      ev = core_q.size() > 0 && core_q[0].cyc < cyc;
      check("core_rsp_valid", core_rsp_valid, ev);
      if (ev) begin
        e = core_q.pop_front();
        check("core_rsp_data", core_rsp_data, e.data);
        last_core = e.data;
      end else check("core_rsp_hold", core_rsp_data, last_core);
      ev = ldr_q.size() > 0 && ldr_q[0].cyc < cyc;
      check("ldr_rsp_valid", ldr_rsp_valid, ev);
      if (ev) begin
        e = ldr_q.pop_front();
        check("ldr_rsp_data", ldr_rsp_data, e.data);
        last_ldr = e.data;
      end else check("ldr_rsp_hold", ldr_rsp_data, last_ldr);
    end
  end

  function automatic logic [ADDR_WIDTH-1:0] raddr();
    if ($urandom_range(0, 8) == 8) return ADDR_WIDTH'(MEM_SIZE - 1);
    return ADDR_WIDTH'($urandom_range(0, 7));
  endfunction

  // Presents requests on both ports and holds each until the model reports it accepted.
  task automatic run_ops(input bit cv, input bit cw, input logic [ADDR_WIDTH-1:0] ca,
                         input logic [DATA_WIDTH-1:0] cd, input bit lv, input bit lw,
                         input logic [ADDR_WIDTH-1:0] la, input logic [DATA_WIDTH-1:0] ld);
    bit cp = cv, lp = lv;
    core_valid = cv; core_wren = cw; core_addr = ca; core_wdata = cd;
    ldr_valid  = lv; ldr_wren  = lw; ldr_addr  = la; ldr_wdata  = ld;
    for (int i = 0; i < 40 && (cp || lp); i++) begin
      @(posedge clk); #1;
      if (cp && core_acc) begin cp = 0; core_valid = 0; end
      if (lp && ldr_acc)  begin lp = 0; ldr_valid = 0; end
    end
    check("op_timeout", {30'd0, cp, lp}, 0);
    core_valid = 0;
    ldr_valid  = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bit lp;
    for (int i = 0; i < MEM_SIZE; i++) begin
      mem[i]     = DATA_WIDTH'(i * 7 + 3);
      ref_mem[i] = DATA_WIDTH'(i * 7 + 3);
    end
    #2;
    check("reset_core_rsp_valid", core_rsp_valid, 0);
    check("reset_ldr_rsp_valid", ldr_rsp_valid, 0);
    check("reset_core_rsp_data", core_rsp_data, 0);
    check("reset_ldr_rsp_data", ldr_rsp_data, 0);
    check("reset_ram_wren", ram_wren, 0);
    repeat (3) @(posedge clk);
    #1 rst = 0;

    idle(10);
    run_ops(1, 1, 8'd5, 16'h1234, 0, 0, '0, '0);
    run_ops(1, 0, 8'd5, '0, 0, 0, '0, '0);
    idle(2);

    run_ops(1, 1, 8'd1, 16'h00AA, 0, 0, '0, '0);
    run_ops(1, 1, 8'd2, 16'h00BB, 0, 0, '0, '0);
    run_ops(1, 0, 8'd1, '0, 1, 0, 8'd2, '0);
    idle(2);

    // Core hammers writes while the loader waits for its read.
    ldr_valid = 1; ldr_wren = 0; ldr_addr = 8'd5;
    core_valid = 1; core_wren = 1; core_addr = 8'd20; core_wdata = 16'h0001;
    lp = 1;
    for (int i = 0; i < 40 && lp; i++) begin
      @(posedge clk); #1;
      if (ldr_acc) begin lp = 0; ldr_valid = 0; end
      if (core_acc) begin core_addr = core_addr + 1; core_wdata = DATA_WIDTH'($urandom); end
    end
    check("starve_timeout", {31'd0, lp}, 0);
    idle(3);
    core_valid = 0;
    idle(2);

    run_ops(0, 0, '0, '0, 1, 1, ADDR_WIDTH'(MEM_SIZE - 1), 16'hFFFF);
    run_ops(0, 0, '0, '0, 1, 0, ADDR_WIDTH'(MEM_SIZE - 1), '0);
    idle(2);

    // Asynchronous reset while a read response is on the port.
    run_ops(1, 0, 8'd5, '0, 0, 0, '0, '0);
    #1 rst = 1;
    #1;
    check("midrst_core_rsp_valid", core_rsp_valid, 0);
    check("midrst_core_rsp_data", core_rsp_data, 0);
    check("midrst_ldr_rsp_valid", ldr_rsp_valid, 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 0;
    run_ops(1, 0, 8'd2, '0, 0, 0, '0, '0);
    idle(2);

    repeat (1500) begin
      @(posedge clk); #1;
      if (!core_valid || core_acc) begin
        core_valid = ($urandom_range(0, 9) < 6);
        core_wren  = 1'($urandom_range(0, 1));
        core_addr  = raddr();
        core_wdata = DATA_WIDTH'($urandom);
      end
      if (!ldr_valid || ldr_acc) begin
        ldr_valid = ($urandom_range(0, 9) < 4);
        ldr_wren  = 1'($urandom_range(0, 1));
        ldr_addr  = raddr();
        ldr_wdata = DATA_WIDTH'($urandom);
      end
    end
    core_valid = 0;
    ldr_valid  = 0;
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
